// File: rtl/fb_pixel_writer.sv
// Writer for the 40x30 monochrome VGA framebuffer: draws 8-pixel runs or clears the whole bitmap.
// Define FB_DOUBLE_BUFFER_EN for front/back buffers swapped on a vsync falling edge.
module fb_pixel_writer #(
  parameter int unsigned WIDTH  = 40,
  parameter int unsigned HEIGHT = 30,
  parameter int unsigned RUN    = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [5:0]              cmd_x,
  input  logic [4:0]              cmd_y,
  input  logic [RUN-1:0]          cmd_pattern,
  input  logic                    swap_req,
  input  logic                    vsync_in,
  output logic                    busy,
  output logic                    swap_done,
  output logic [WIDTH*HEIGHT-1:0] framebuffer
);

  localparam int unsigned PixW = $clog2(RUN);
  localparam logic [1:0] OpDraw  = 2'b00;
  localparam logic [1:0] OpOr    = 2'b01;
  localparam logic [1:0] OpClear = 2'b10;
  localparam logic [1:0] OpNop   = 2'b11;

`ifdef FB_DOUBLE_BUFFER_EN
  typedef enum logic [1:0] {StIdle, StDraw, StClear, StSwapWait} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDraw, StClear} state_e;
`endif

  state_e                  r_state;
  logic [1:0]              r_op;
  logic [5:0]              r_x;
  logic [4:0]              r_y;
  logic [RUN-1:0]          r_pat;
  logic [PixW-1:0]         r_pix;
  logic [4:0]              r_row;
  logic [WIDTH*HEIGHT-1:0] r_back;

  logic [6:0]              w_col;
  logic [10:0]             w_idx;
  logic [10:0]             w_row_base;
  logic [RUN-1:0]          w_pat_sh;
  logic                    w_pix_bit;
  logic                    w_in_range;
  logic                    w_last_pix;

  assign w_col      = {1'b0, r_x} + 7'(r_pix);
  assign w_idx      = 11'(r_y) * 11'(WIDTH) + 11'(w_col);
  assign w_row_base = 11'(r_row) * 11'(WIDTH);
  assign w_pat_sh   = r_pat << r_pix;
  assign w_pix_bit  = w_pat_sh[RUN-1];
  // Clip at the right edge instead of wrapping into the next row.
  assign w_in_range = (r_y < 5'(HEIGHT)) && (w_col < 7'(WIDTH));
  // NOP shares the draw state but leaves after a single cycle.
  assign w_last_pix = (r_pix == PixW'(RUN - 1)) || (r_op == OpNop);

  assign cmd_ready = (r_state == StIdle);
  assign busy      = ~cmd_ready;

`ifdef FB_DOUBLE_BUFFER_EN
  logic [WIDTH*HEIGHT-1:0] r_front;
  logic                    r_vsync;
  logic                    r_vsync_d;
  logic                    r_swap_done;
  logic                    w_frame_edge;

  assign w_frame_edge = r_vsync_d & ~r_vsync;
  assign framebuffer  = r_front;
  assign swap_done    = r_swap_done;
`else
  logic w_unused;
  assign w_unused    = ^{swap_req, vsync_in};
  assign framebuffer = r_back;
  assign swap_done   = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_op    <= OpNop;
      r_x     <= '0;
      r_y     <= '0;
      r_pat   <= '0;
      r_pix   <= '0;
      r_row   <= '0;
      r_back  <= '0;
`ifdef FB_DOUBLE_BUFFER_EN
      r_front     <= '0;
      r_vsync     <= 1'b0;
      r_vsync_d   <= 1'b0;
      r_swap_done <= 1'b0;
`endif
    end else begin
`ifdef FB_DOUBLE_BUFFER_EN
      r_vsync     <= vsync_in;
      r_vsync_d   <= r_vsync;
      r_swap_done <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_x     <= cmd_x;
            r_y     <= cmd_y;
            r_pat   <= cmd_pattern;
            r_pix   <= '0;
            r_row   <= '0;
            r_state <= (cmd_op == OpClear) ? StClear : StDraw;
          end
`ifdef FB_DOUBLE_BUFFER_EN
          else if (swap_req) begin
            r_state <= StSwapWait;
          end
`endif
        end
        StDraw: begin
          if (w_in_range && (r_op == OpDraw)) begin
            r_back[w_idx] <= w_pix_bit;
          end else if (w_in_range && (r_op == OpOr) && w_pix_bit) begin
            r_back[w_idx] <= 1'b1;
          end
          r_pix <= r_pix + PixW'(1);
          if (w_last_pix) begin
            r_pix   <= '0;
            r_state <= StIdle;
          end
        end
        StClear: begin
          r_back[w_row_base +: WIDTH] <= '0;
          r_row <= r_row + 5'd1;
          if (r_row == 5'(HEIGHT - 1)) begin
            r_row   <= '0;
            r_state <= StIdle;
          end
        end
`ifdef FB_DOUBLE_BUFFER_EN
        StSwapWait: begin
          if (w_frame_edge) begin
            r_front     <= r_back;
            r_swap_done <= 1'b1;
            r_state     <= StIdle;
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
